// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: drives an 8:1 bit-select mux through all eight selects and reassembles its output
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - scan request, honoured only while idle
//   abort    - synchronous cancel of an in-progress scan
//   data_in  - word latched onto the mux data input at acceptance
//   mux_f    - mux output fed back (combinational from mux_in/mux_sel)
//   mux_in   - latched word driving the mux data input
//   mux_sel  - mux select, stepped once per clock while scanning
//   busy     - high from acceptance until the return to idle
//   done     - one-cycle pulse when rx_data is refreshed
//   rx_data  - reassembled byte, held until the next done
//   err      - registered mismatch flag (rx_data vs mux_in)
//
// Parameter DIR: 0 scans select 0->7, 1 scans select 7->0.
// Macro MUX_SEQ_CHECK_EN: when defined, builds the rx_data/mux_in compare
// driving err; otherwise err is tied low.
module mux_sel_sequencer #(
    parameter bit DIR = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] data_in,
    input  logic       mux_f,
    output logic [7:0] mux_in,
    output logic [2:0] mux_sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [2:0] FIRST = DIR ? 3'd7 : 3'd0;

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] shadow;
    logic [7:0] captured;
    logic [2:0] nxt_sel;

    // Bits land at their select index, so arrival order does not matter.
    always_comb begin
        captured          = shadow;
        captured[mux_sel] = mux_f;
    end

    assign nxt_sel = DIR ? mux_sel - 3'd1 : mux_sel + 3'd1;

`ifndef MUX_SEQ_CHECK_EN
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mux_in  <= 8'd0;
            mux_sel <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= 8'd0;
            cnt     <= 3'd0;
            shadow  <= 8'd0;
`ifdef MUX_SEQ_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= SCAN;
                    busy    <= 1'b1;
                    mux_in  <= data_in;
                    mux_sel <= FIRST;
                    cnt     <= 3'd0;
`ifdef MUX_SEQ_CHECK_EN
                    err     <= 1'b0;
`endif
                end
                SCAN: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    shadow  <= captured;
                    mux_sel <= nxt_sel;
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rx_data <= captured;
                        done    <= 1'b1;
                        state   <= DONE;
`ifdef MUX_SEQ_CHECK_EN
                        err     <= captured != mux_in;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: directed bench running DIR=0 and DIR=1 instances side by side
module tb_mux_sel_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       inj = 1'b0;
    int         errors = 0;
    int         checks = 0;

    logic [7:0] in0, in1, rx0, rx1;
    logic [2:0] sel0, sel1;
    logic       f0, f1, busy0, busy1, done0, done1, err0, err1;

`ifdef MUX_SEQ_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    // Behavioural mux, optionally corrupting the bit at select 5.
    assign f0 = in0[sel0] ^ (inj && sel0 == 3'd5);
    assign f1 = in1[sel1] ^ (inj && sel1 == 3'd5);

    mux_sel_sequencer #(.DIR(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .data_in(data_in),
        .mux_f(f0), .mux_in(in0), .mux_sel(sel0), .busy(busy0), .done(done0),
        .rx_data(rx0), .err(err0)
    );

    mux_sel_sequencer #(.DIR(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .data_in(data_in),
        .mux_f(f1), .mux_in(in1), .mux_sel(sel1), .busy(busy1), .done(done1),
        .rx_data(rx1), .err(err1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic both(input string tag, input logic [7:0] g0, input logic [7:0] g1, input logic [7:0] exp);
        check({tag, "_d0"}, g0, exp);
        check({tag, "_d1"}, g1, exp);
    endtask

    // Full scan of d from E0 through E9 with select/handshake checks on both instances.
    task automatic run_scan(input logic [7:0] d, input logic [7:0] exp_rx, input logic exp_err);
        data_in = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        both("e0_busy", {7'd0, busy0}, {7'd0, busy1}, 8'd1);
        both("e0_mux_in", in0, in1, d);
        both("e0_err", {7'd0, err0}, {7'd0, err1}, 8'd0);
        check("e0_sel_d0", {5'd0, sel0}, 8'd0);
        check("e0_sel_d1", {5'd0, sel1}, 8'd7);
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("e%0d_sel_d0", k), {5'd0, sel0}, 8'(k));
            check($sformatf("e%0d_sel_d1", k), {5'd0, sel1}, 8'(7 - k));
            both($sformatf("e%0d_busy", k), {7'd0, busy0}, {7'd0, busy1}, 8'd1);
            both($sformatf("e%0d_done", k), {7'd0, done0}, {7'd0, done1}, 8'd0);
        end
        tick();
        both("e8_done", {7'd0, done0}, {7'd0, done1}, 8'd1);
        both("e8_busy", {7'd0, busy0}, {7'd0, busy1}, 8'd1);
        both("e8_rx", rx0, rx1, exp_rx);
        both("e8_err", {7'd0, err0}, {7'd0, err1}, {7'd0, exp_err});
        check("e8_sel_d0", {5'd0, sel0}, 8'd0);
        check("e8_sel_d1", {5'd0, sel1}, 8'd7);
        tick();
        both("e9_done", {7'd0, done0}, {7'd0, done1}, 8'd0);
        both("e9_busy", {7'd0, busy0}, {7'd0, busy1}, 8'd0);
        both("e9_rx", rx0, rx1, exp_rx);
        both("e9_err", {7'd0, err0}, {7'd0, err1}, {7'd0, exp_err});
    endtask

    initial begin
        #2;
        both("rst_busy", {7'd0, busy0}, {7'd0, busy1}, 8'd0);
        both("rst_rx", rx0, rx1, 8'd0);
        both("rst_mux_in", in0, in1, 8'd0);
        both("rst_sel", {5'd0, sel0}, {5'd0, sel1}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_scan(8'hF1, 8'hF1, 1'b0);

        // Abort on E4 of a 0F scan: no done, rx_data keeps F1, mux_in keeps 0F.
        data_in = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        both("abort_busy", {7'd0, busy0}, {7'd0, busy1}, 8'd0);
        both("abort_done", {7'd0, done0}, {7'd0, done1}, 8'd0);
        repeat (6) begin
            tick();
            both("abort_nodone", {7'd0, done0}, {7'd0, done1}, 8'd0);
        end
        both("abort_rx", rx0, rx1, 8'hF1);
        both("abort_mux_in", in0, in1, 8'h0F);
        run_scan(8'h3C, 8'h3C, 1'b0);

        // Second start at E3 and again during DONE must be ignored.
        data_in = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        data_in = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        both("restart_mux_in", in0, in1, 8'hA5);
        repeat (5) tick();
        both("restart_done", {7'd0, done0}, {7'd0, done1}, 8'd1);
        both("restart_rx", rx0, rx1, 8'hA5);
        start = 1'b1;
        tick();
        start = 1'b0;
        both("done_start_busy", {7'd0, busy0}, {7'd0, busy1}, 8'd0);
        both("done_start_mux_in", in0, in1, 8'hA5);
        tick();
        both("done_start_idle", {7'd0, busy0}, {7'd0, busy1}, 8'd0);

        // Asynchronous reset in the middle of the cycle after E5.
        data_in = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        both("arst_busy", {7'd0, busy0}, {7'd0, busy1}, 8'd0);
        both("arst_rx", rx0, rx1, 8'd0);
        both("arst_mux_in", in0, in1, 8'd0);
        both("arst_sel", {5'd0, sel0}, {5'd0, sel1}, 8'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            both("post_rst_done", {7'd0, done0}, {7'd0, done1}, 8'd0);
            both("post_rst_busy", {7'd0, busy0}, {7'd0, busy1}, 8'd0);
        end

        // Corrupted bit 5: F1 becomes D1; err flags it when the check is built.
        inj = 1'b1;
        run_scan(8'hF1, 8'hD1, CHK);
        inj = 1'b0;
        run_scan(8'hF1, 8'hF1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
